lane_combat_scheduler: RTL
==========================

Name: lane_combat_scheduler

Overview:
- Per-game-tick sequencer for one lane of NUM_ENEMY enemy units.
- On each tick it scans all enemy slots, picks the single frontmost enemy in contact with the player, and issues one-cycle moveSCEN/damageSCEN strobes to each enemy in turn.
- It sums the attack power of every enemy in contact into a saturated playerDamage value.
- It sits between the game-tick generator, the enemy unit instances and the player unit in the top level.

Parameters:
- NUM_ENEMY, 4, number of enemy slots (at least 1).
- POS_W, 9, position width.
- DMG_W, 8, damage/power width.
- RANGE, 1, contact distance: an enemy is in contact when enemyPos + RANGE >= playerFront.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- gameTick  in  1  one-cycle tick pulse, synchronous to clk.
- enemyAlive  in  NUM_ENEMY  per-slot alive flag.
- enemyPos  in  NUM_ENEMY*POS_W  packed positions; slot i is at [i*POS_W +: POS_W].
- enemyPower  in  NUM_ENEMY*DMG_W  packed attack power per slot.
- playerFront  in  POS_W  position of the player's front unit.
- playerPower  in  DMG_W  damage the player deals per tick.
- moveSCEN  out  NUM_ENEMY  one-hot, one-cycle move strobe.
- damageSCEN  out  NUM_ENEMY  one-hot, one-cycle damage-accept strobe.
- damageIn  out  DMG_W  damage value for the strobed slot.
- playerDamage  out  DMG_W  damage dealt to the player in the last frame.
- playerHit  out  1  one-cycle pulse: the frame ended with playerDamage != 0.
- busy  out  1  high while a frame is in progress.
- overrun  out  1  sticky flag: a tick arrived while not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including overrun.
  - Internal index, target and accumulator registers are cleared.
- States: IDLE, FIND, ISSUE, DONE. Binary encoding, defined in the package.
- Frame timing, for a tick accepted at cycle t:
  - t+1 .. t+NUM_ENEMY: FIND.
  - t+NUM_ENEMY+1 .. t+2*NUM_ENEMY: ISSUE.
  - t+2*NUM_ENEMY+1: DONE.
  - IDLE again from t+2*NUM_ENEMY+2.
- IDLE:
  - gameTick=1 latches playerFront and playerPower, clears the accumulator, sets idx=0, hasTarget=0, and goes to FIND.
  - busy=0 only in IDLE.
- FIND: one slot per cycle, idx 0..NUM_ENEMY-1.
  - A slot is in contact when alive and {1'b0,pos}+RANGE >= {1'b0,frontLatched}, using POS_W+1-bit arithmetic so there is no wrap.
  - In-contact slot: add its enemyPower to the accumulator, saturating at 2^DMG_W-1.
  - It becomes the target if hasTarget=0 or its pos > the current target's pos.
  - Ties keep the lower index.
  - After the last slot: idx=0, go to ISSUE.
- ISSUE: one slot per cycle. Outputs are registered, so the strobe for slot idx is visible in that ISSUE cycle.
  - Slot not alive now (alive is re-sampled): no strobe.
  - Slot is the target: damageSCEN[idx]=1 and damageIn=playerPower latched at tick.
  - Slot is alive, not the target, and in contact (recomputed with the latched front): no strobe, because the enemy attacks by default.
  - Otherwise: moveSCEN[idx]=1.
  - damageIn=0 whenever damageSCEN=0.
  - At most one bit of moveSCEN|damageSCEN is set per cycle.
- Target dies between FIND and ISSUE: no damage strobe, no retarget. The accumulated damage still counts.
- DONE:
  - playerDamage <= accumulator.
  - playerHit=1 for this cycle if the accumulator != 0.
  - Go to IDLE.
  - playerDamage holds its value until the next DONE, and is updated to 0 on a frame with no contact.
- A gameTick in FIND, ISSUE or DONE is dropped and sets overrun=1. overrun is cleared only by reset.
- NUM_ENEMY=1: the same sequence with one FIND and one ISSUE cycle.

Decomposition:
- lane_pkg holds:
  - the state encoding localparams (IDLE/FIND/ISSUE/DONE);
  - POS_W and DMG_W defaults;
  - a function sat_add(a,b) returning a DMG_W-bit saturated sum.
- One sub-module: lane_contact_check. Combinational; inputs pos, front, RANGE; output contact. It is instantiated once, muxed by idx, and shared by FIND and ISSUE.

Test Plan:
Unless noted: NUM_ENEMY=4, RANGE=1, tick at t.
1. No contact: alive=1111, pos=0/10/20/30, front=100 -> moveSCEN=0001,0010,0100,1000 at t+5..t+8; damageSCEN never set; playerDamage=0 and playerHit=0 at t+9; busy=1 for t+1..t+9.
2. Contact, tie-break: pos=99/100/50/100, power=16/32/64/128, front=100, playerPower=40 -> target slot 1; t+5 no strobe; t+6 damageSCEN=0010 with damageIn=40; t+7 moveSCEN=0100; t+8 no strobe; t+9 playerDamage=176 and playerHit=1.
3. Saturation: all slots pos=100, power=128, front=100 -> playerDamage=255 at t+9; only damageSCEN[0] at t+5.
4. Overrun: ticks at t and t+3 -> overrun=1 from t+4; exactly one frame of strobes; the next tick at t+10 is accepted.
5. Target dies: scenario 2 with alive[1] dropped at t+5 -> no strobe at t+6; playerDamage=176 at t+9.
6. Reset mid-frame: reset=0 at t+6 -> all outputs 0 immediately and overrun cleared; after release, a tick starts a clean frame.

Source files
------------

// File: rtl/lane_pkg.sv
// lane_pkg: shared state encoding, default widths and saturating add for the lane scheduler
package lane_pkg;
  localparam int DEF_POS_W = 9;
  localparam int DEF_DMG_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, FIND = 2'd1, ISSUE = 2'd2, DONE = 2'd3} state_t;
  function automatic logic [DEF_DMG_W-1:0] sat_add(input logic [DEF_DMG_W-1:0] a, input logic [DEF_DMG_W-1:0] b);
    logic [DEF_DMG_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DEF_DMG_W] ? '1 : s[DEF_DMG_W-1:0];
  endfunction
endpackage

// File: rtl/lane_contact_check.sv
// lane_contact_check: enemy at pos touches the player front when pos + RANGE >= front, without wrap
module lane_contact_check #(
  parameter int POS_W = 9,
  parameter int RANGE = 1
) (
  input  logic [POS_W-1:0] pos,
  input  logic [POS_W-1:0] front,
  output logic             contact
);
  assign contact = ({1'b0, pos} + (POS_W+1)'(RANGE)) >= {1'b0, front};
endmodule

// File: rtl/lane_combat_scheduler.sv
// lane_combat_scheduler: per-tick scan of enemy slots, target pick, move/damage strobes and player damage sum
module lane_combat_scheduler
  import lane_pkg::*;
#(
  parameter int NUM_ENEMY = 4,
  parameter int POS_W     = DEF_POS_W,
  parameter int DMG_W     = DEF_DMG_W,
  parameter int RANGE     = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       gameTick,
  input  logic [NUM_ENEMY-1:0]       enemyAlive,
  input  logic [NUM_ENEMY*POS_W-1:0] enemyPos,
  input  logic [NUM_ENEMY*DMG_W-1:0] enemyPower,
  input  logic [POS_W-1:0]           playerFront,
  input  logic [DMG_W-1:0]           playerPower,
  output logic [NUM_ENEMY-1:0]       moveSCEN,
  output logic [NUM_ENEMY-1:0]       damageSCEN,
  output logic [DMG_W-1:0]           damageIn,
  output logic [DMG_W-1:0]           playerDamage,
  output logic                       playerHit,
  output logic                       busy,
  output logic                       overrun
);
  localparam int IW = NUM_ENEMY > 1 ? $clog2(NUM_ENEMY) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_ENEMY - 1);
  state_t state, state_n;
  logic [IW-1:0] idx, idx_inc, chk_idx, tgt_idx, tgt_idx_n;
  logic [POS_W-1:0] front_q, tgt_pos;
  logic [DMG_W-1:0] pow_q, acc;
  logic [POS_W-1:0] pos_a [NUM_ENEMY];
  logic [DMG_W-1:0] pwr_a [NUM_ENEMY];
  logic [NUM_ENEMY-1:0] onehot;
  logic last, contact, hit, take, has_tgt, has_tgt_n, c0, issue_go, iss_contact, is_tgt, mv, dm;

  always_comb begin
    for (int i = 0; i < NUM_ENEMY; i++) begin
      pos_a[i] = enemyPos[i*POS_W +: POS_W];
      pwr_a[i] = enemyPower[i*DMG_W +: DMG_W];
    end
  end

  assign last    = idx == LAST;
  assign idx_inc = last ? '0 : idx + IW'(1);
  // ISSUE registers the strobe one cycle ahead, so the checker looks at the next slot
  assign chk_idx = state == ISSUE ? idx_inc : idx;

  lane_contact_check #(.POS_W(POS_W), .RANGE(RANGE)) u_chk (
    .pos    (pos_a[chk_idx]),
    .front  (front_q),
    .contact(contact)
  );

  assign hit       = state == FIND && enemyAlive[chk_idx] && contact;
  assign take      = hit && (!has_tgt || pos_a[chk_idx] > tgt_pos);
  assign has_tgt_n = has_tgt | take;
  assign tgt_idx_n = take ? idx : tgt_idx;
  assign issue_go  = (state == FIND && last) || (state == ISSUE && !last);
  // slot 0's contact was captured during its FIND cycle, while the checker is busy with the last slot
  assign iss_contact = (state == FIND && NUM_ENEMY > 1) ? c0 : contact;
  assign is_tgt    = has_tgt_n && tgt_idx_n == idx_inc;
  assign dm        = issue_go && enemyAlive[idx_inc] && is_tgt;
  assign mv        = issue_go && enemyAlive[idx_inc] && !is_tgt && !iss_contact;
  assign onehot    = NUM_ENEMY'(1) << idx_inc;
  assign busy      = state != IDLE;

  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (gameTick ? FIND : IDLE) :
              state == FIND  ? (last ? ISSUE : FIND) :
              state == ISSUE ? (last ? DONE : ISSUE) : IDLE;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx          <= '0;
      tgt_idx      <= '0;
      tgt_pos      <= '0;
      has_tgt      <= 1'b0;
      c0           <= 1'b0;
      front_q      <= '0;
      pow_q        <= '0;
      acc          <= '0;
      moveSCEN     <= '0;
      damageSCEN   <= '0;
      damageIn     <= '0;
      playerDamage <= '0;
      playerHit    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (state == IDLE && gameTick) begin
        front_q <= playerFront;
        pow_q   <= playerPower;
        acc     <= '0;
        idx     <= '0;
        has_tgt <= 1'b0;
        tgt_idx <= '0;
        tgt_pos <= '0;
      end
      if (state == FIND) begin
        if (hit) acc <= sat_add(acc, pwr_a[chk_idx]);
        if (take) tgt_pos <= pos_a[chk_idx];
        if (idx == '0) c0 <= contact;
        has_tgt <= has_tgt_n;
        tgt_idx <= tgt_idx_n;
      end
      if (state == FIND || state == ISSUE) idx <= idx_inc;
      if (state == ISSUE && last) playerDamage <= acc;
      if (gameTick && state != IDLE) overrun <= 1'b1;
      moveSCEN   <= mv ? onehot : '0;
      damageSCEN <= dm ? onehot : '0;
      damageIn   <= dm ? pow_q : '0;
      playerHit  <= state == ISSUE && last && acc != '0;
    end
  end
endmodule
